// File: rtl/mem_bus_responder_pkg.sv
// Shared definitions for the MEM-stage bus responder: MMIO map, register selector and TCON bit layout.
package mem_bus_responder_pkg;

   localparam logic [31:0] MMIO_BASE = 32'h4000_0000;

   localparam int TCON_EN = 0;
   localparam int TCON_IE = 1;
   localparam int TCON_ST = 2;

   typedef enum logic [2:0] {
      REG_TH      = 3'd0,
      REG_TL      = 3'd1,
      REG_TCON    = 3'd2,
      REG_LED     = 3'd3,
      REG_DIGITS  = 3'd4,
      REG_SYSTICK = 3'd5,
      REG_NONE    = 3'd7
   } mmio_reg_e;

   // Word offset within the 32-byte MMIO window selects the register.
   function automatic mmio_reg_e decode_mmio(input logic [31:2] word_addr);
      if (word_addr[31:5] != MMIO_BASE[31:5]) return REG_NONE;
      case (word_addr[4:2])
         3'd0:    return REG_TH;
         3'd1:    return REG_TL;
         3'd2:    return REG_TCON;
         3'd3:    return REG_LED;
         3'd4:    return REG_DIGITS;
         3'd5:    return REG_SYSTICK;
         default: return REG_NONE;
      endcase
   endfunction

endpackage

// File: rtl/mem_bus_responder_if.sv
// Request/response channel between the CPU MEM stage (master) and the bus responder (slave).
interface mem_bus_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_bus_responder_mmio_timer.sv
// TH/TL/TCON reload timer with W1C interrupt status, plus a free-running SYSTICK counter.
module mmio_timer
   import mem_bus_responder_pkg::*;
#(
   parameter int TIMER_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_th,
   input  logic               wr_tl,
   input  logic               wr_tcon,
   input  logic [31:0]        wdata,
   output logic [TIMER_W-1:0] th,
   output logic [TIMER_W-1:0] tl,
   output logic [TIMER_W-1:0] systick,
   output logic [2:0]         tcon,
   output logic               irq
);

   localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

   logic ovf;
   assign ovf = tcon[TCON_EN] && (tl == '1);
   assign irq = tcon[TCON_IE] & tcon[TCON_ST];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         th      <= '0;
         tl      <= '0;
         systick <= '0;
         tcon    <= '0;
      end else begin
         systick <= systick + ONE;
         if (wr_th) th <= wdata[TIMER_W-1:0];
         // Software write to TL beats both reload and increment.
         if (wr_tl)                tl <= wdata[TIMER_W-1:0];
         else if (ovf)             tl <= th;
         else if (tcon[TCON_EN])   tl <= tl + ONE;
         if (wr_tcon) begin
            tcon[TCON_EN] <= wdata[TCON_EN];
            tcon[TCON_IE] <= wdata[TCON_IE];
         end
         // A fresh overflow wins over a same-cycle W1C so no interrupt is lost.
         tcon[TCON_ST] <= (tcon[TCON_ST] && !(wr_tcon && wdata[TCON_ST]))
                          || (ovf && tcon[TCON_IE]);
      end
   end

endmodule

// File: rtl/mem_bus_responder.sv
// MEM-stage data bus responder: word RAM, LED/DIGITS registers, timer block and one-cycle response stage.
module mem_bus_responder
   import mem_bus_responder_pkg::*;
#(
   parameter int RAM_WORDS = 256,
   parameter int TIMER_W   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_bus_responder_if.slave   bus,
   output logic [7:0]           led,
   output logic [15:0]          digits,
   output logic                 timer_irq
);

   localparam int AW = $clog2(RAM_WORDS);

   logic              ready;
   logic              accept, aligned, ram_hit, wr_ok, rd_ok;
   logic [AW-1:0]     ram_idx;
   mmio_reg_e         reg_sel;
   logic [31:0]       reg_rdata;
   logic [TIMER_W-1:0] th, tl, systick;
   logic [2:0]        tcon;

   logic [31:0] ram [RAM_WORDS];
   logic [31:0] ram_q_p1;
   logic        rsp_vld_p1, rsp_err_p1, sel_ram_p1;
   logic [31:0] reg_q_p1;

   assign accept  = bus.req_valid && ready;
   assign aligned = (bus.req_addr[1:0] == 2'b00);
   assign ram_hit = (bus.req_addr[31:AW+2] == '0);
   assign ram_idx = bus.req_addr[AW+1:2];
   assign reg_sel = decode_mmio(bus.req_addr[31:2]);
   assign wr_ok   = accept && bus.req_write && aligned;
   assign rd_ok   = accept && !bus.req_write && aligned;

   mmio_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .wr_th   (wr_ok && (reg_sel == REG_TH)),
      .wr_tl   (wr_ok && (reg_sel == REG_TL)),
      .wr_tcon (wr_ok && (reg_sel == REG_TCON)),
      .wdata   (bus.req_wdata),
      .th      (th),
      .tl      (tl),
      .systick (systick),
      .tcon    (tcon),
      .irq     (timer_irq)
   );

   always_comb begin
      reg_rdata = '0;
      case (reg_sel)
         REG_TH:      reg_rdata = 32'(th);
         REG_TL:      reg_rdata = 32'(tl);
         REG_TCON:    reg_rdata = {29'd0, tcon};
         REG_LED:     reg_rdata = {24'd0, led};
         REG_DIGITS:  reg_rdata = {16'd0, digits};
         REG_SYSTICK: reg_rdata = 32'(systick);
         default:     reg_rdata = '0;
      endcase
   end

   // RAM contents are deliberately not reset; the read port is registered into the response stage.
   always_ff @(posedge clk) begin
      if (wr_ok && ram_hit) ram[ram_idx] <= bus.req_wdata;
      if (accept)           ram_q_p1     <= ram[ram_idx];
   end

   // Stage p0 -> p1: accepted request becomes next cycle's response.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ready      <= 1'b0;
         rsp_vld_p1 <= 1'b0;
         rsp_err_p1 <= 1'b0;
         sel_ram_p1 <= 1'b0;
         reg_q_p1   <= '0;
         led        <= '0;
         digits     <= '0;
      end else begin
         ready      <= 1'b1;
         rsp_vld_p1 <= accept;
         rsp_err_p1 <= accept && !aligned;
         sel_ram_p1 <= rd_ok && ram_hit;
         reg_q_p1   <= rd_ok ? reg_rdata : '0;
         if (wr_ok && (reg_sel == REG_LED))    led    <= bus.req_wdata[7:0];
         if (wr_ok && (reg_sel == REG_DIGITS)) digits <= bus.req_wdata[15:0];
      end
   end

   assign bus.req_ready = ready;
   assign bus.rsp_valid = rsp_vld_p1;
   assign bus.rsp_err   = rsp_err_p1;
   assign bus.rsp_rdata = sel_ram_p1 ? ram_q_p1 : reg_q_p1;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Scoreboard bench for mem_bus_responder: expected responses queued at issue, compared when rsp_valid fires.
module tb_mem_bus_responder;
   import mem_bus_responder_pkg::*;

   localparam logic [31:0] A_TH      = 32'h4000_0000;
   localparam logic [31:0] A_TL      = 32'h4000_0004;
   localparam logic [31:0] A_TCON    = 32'h4000_0008;
   localparam logic [31:0] A_LED     = 32'h4000_000C;
   localparam logic [31:0] A_DIGITS  = 32'h4000_0010;
   localparam logic [31:0] A_SYSTICK = 32'h4000_0014;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [7:0]  led;
   logic [15:0] digits;
   logic        timer_irq;

   mem_bus_responder_if bus();

   mem_bus_responder #(.RAM_WORDS(256), .TIMER_W(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .led       (led),
      .digits    (digits),
      .timer_irq (timer_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned acc;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned cyc;
   int          checks = 0;
   int          errors = 0;

   // Cycle count since reset release; also the reference value for SYSTICK.
   always @(posedge clk or negedge reset) begin
      if (!reset) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   task automatic bus_op(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
      exp_t e;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      check("req_ready", 32'(bus.req_ready), 32'd1);
      e.acc   = cyc + 1;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset) begin
         if (bus.rsp_valid) begin
            if (sb_q.size() == 0) begin
               check("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
               e = sb_q.pop_front();
               check("rsp_latency", cyc, e.acc);
               check("rsp_rdata", bus.rsp_rdata, e.rdata);
               check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
            end
         end else begin
            check("idle_rdata", {bus.rsp_rdata[31:1], bus.rsp_rdata[0] | bus.rsp_err}, 32'd0);
            if (sb_q.size() > 0 && sb_q[0].acc <= cyc) begin
               check("missing_rsp", 32'(bus.rsp_valid), 32'd1);
               void'(sb_q.pop_front());
            end
         end
      end
   end

   initial begin
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;

      #2;
      check("rst_ready",   32'(bus.req_ready), 32'd0);
      check("rst_rspv",    32'(bus.rsp_valid), 32'd0);
      check("rst_led",     32'(led),           32'd0);
      check("rst_digits",  32'(digits),        32'd0);
      check("rst_irq",     32'(timer_irq),     32'd0);
      @(posedge clk);
      #3 reset = 1'b1;
      check("release_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk);
      #1;
      check("ready_up", 32'(bus.req_ready), 32'd1);

      // RAM store then immediate load of the same word
      bus_op(1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
      bus_op(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);

      // LED and DIGITS, upper bits dropped
      bus_op(1'b1, A_LED, 32'h0000_00A5, 32'h0, 1'b0);
      check("led_store", 32'(led), 32'h0000_00A5);
      bus_op(1'b0, A_LED, 32'h0, 32'h0000_00A5, 1'b0);
      bus_op(1'b1, A_DIGITS, 32'hFFFF_1234, 32'h0, 1'b0);
      check("digits_store", 32'(digits), 32'h0000_1234);
      bus_op(1'b0, A_DIGITS, 32'h0, 32'h0000_1234, 1'b0);

      // RAM boundary words and the first address past RAM
      bus_op(1'b1, 32'h0,   32'h1111_1111, 32'h0, 1'b0);
      bus_op(1'b1, 32'h3FC, 32'hCAFE_F00D, 32'h0, 1'b0);
      bus_op(1'b1, 32'h400, 32'h5555_5555, 32'h0, 1'b0);
      bus_op(1'b0, 32'h3FC, 32'h0, 32'hCAFE_F00D, 1'b0);
      bus_op(1'b0, 32'h0,   32'h0, 32'h1111_1111, 1'b0);
      bus_op(1'b0, 32'h400, 32'h0, 32'h0, 1'b0);

      // Misaligned and unmapped accesses
      bus_op(1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
      bus_op(1'b1, 32'h4000_0016, 32'hFFFF_FFFF, 32'h0, 1'b1);
      bus_op(1'b1, 32'h12, 32'h0, 32'h0, 1'b1);
      bus_op(1'b1, 32'h4000_000D, 32'h0, 32'h0, 1'b1);
      check("led_after_misaligned", 32'(led), 32'h0000_00A5);
      bus_op(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
      bus_op(1'b0, A_LED, 32'h0, 32'h0000_00A5, 1'b0);
      bus_op(1'b0, A_DIGITS, 32'h0, 32'h0000_1234, 1'b0);
      bus_op(1'b0, 32'h4000_0018, 32'h0, 32'h0, 1'b0);
      bus_op(1'b0, 32'h2000_0000, 32'h0, 32'h0, 1'b0);
      bus_op(1'b1, A_LED, 32'hFFFF_FF3C, 32'h0, 1'b0);
      check("led_upper", 32'(led), 32'h0000_003C);
      bus_op(1'b0, A_LED, 32'h0, 32'h0000_003C, 1'b0);

      // SYSTICK is read-only and free-running
      bus_op(1'b1, A_SYSTICK, 32'h0, 32'h0, 1'b0);
      bus_op(1'b0, A_SYSTICK, 32'h0, cyc, 1'b0);
      bus_op(1'b0, A_SYSTICK, 32'h0, cyc, 1'b0);
      idle(2);

      // Timer overflow and reload
      bus_op(1'b1, A_TH,   32'd5, 32'h0, 1'b0);
      bus_op(1'b1, A_TL,   32'hFFFF_FFFD, 32'h0, 1'b0);
      bus_op(1'b1, A_TCON, 32'h3, 32'h0, 1'b0);
      check("irq_before", 32'(timer_irq), 32'd0);
      bus_op(1'b0, A_TL, 32'h0, 32'hFFFF_FFFD, 1'b0);
      bus_op(1'b0, A_TL, 32'h0, 32'hFFFF_FFFE, 1'b0);
      check("irq_pending", 32'(timer_irq), 32'd0);
      bus_op(1'b0, A_TL, 32'h0, 32'hFFFF_FFFF, 1'b0);
      check("irq_set", 32'(timer_irq), 32'd1);
      bus_op(1'b0, A_TL,   32'h0, 32'd5, 1'b0);
      bus_op(1'b0, A_TCON, 32'h0, 32'h7, 1'b0);

      // W1C coinciding with overflow: set wins; TL write beats increment
      bus_op(1'b1, A_TL,   32'hFFFF_FFFE, 32'h0, 1'b0);
      bus_op(1'b0, A_TL,   32'h0, 32'hFFFF_FFFE, 1'b0);
      bus_op(1'b1, A_TCON, 32'h7, 32'h0, 1'b0);
      check("irq_set_wins", 32'(timer_irq), 32'd1);
      bus_op(1'b0, A_TCON, 32'h0, 32'h7, 1'b0);
      bus_op(1'b1, A_TCON, 32'h6, 32'h0, 1'b0);
      check("irq_cleared", 32'(timer_irq), 32'd0);
      bus_op(1'b0, A_TCON, 32'h0, 32'h2, 1'b0);
      bus_op(1'b0, A_TL,   32'h0, 32'd7, 1'b0);
      bus_op(1'b0, A_TL,   32'h0, 32'd7, 1'b0);
      bus_op(1'b0, A_TH,   32'h0, 32'd5, 1'b0);

      // Re-arm the interrupt before the reset test
      bus_op(1'b1, A_TCON, 32'h3, 32'h0, 1'b0);
      bus_op(1'b1, A_TL,   32'hFFFF_FFFF, 32'h0, 1'b0);
      bus_op(1'b0, A_TL,   32'h0, 32'hFFFF_FFFF, 1'b0);
      check("irq_rearmed", 32'(timer_irq), 32'd1);

      // Reset while a load response is in flight
      bus_op(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
      reset = 1'b0;
      bus.req_valid = 1'b0;
      #1;
      sb_q.delete();
      check("midrst_rspv",   32'(bus.rsp_valid), 32'd0);
      check("midrst_ready",  32'(bus.req_ready), 32'd0);
      check("midrst_led",    32'(led),           32'd0);
      check("midrst_digits", 32'(digits),        32'd0);
      check("midrst_irq",    32'(timer_irq),     32'd0);
      @(posedge clk);
      #3 reset = 1'b1;
      @(posedge clk);
      #1;
      check("ready_again", 32'(bus.req_ready), 32'd1);
      bus_op(1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
      bus_op(1'b0, A_LED,  32'h0, 32'h0, 1'b0);
      bus_op(1'b0, A_TCON, 32'h0, 32'h0, 1'b0);
      idle(3);
      check("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
